// File: rtl/int_to_fp_pipe.sv
// Pipelined integer to IEEE binary floating-point converter.
// Three elastic stages: capture/absolute value, normalise, round/pack.
// Each stage has its own valid bit and can advance whenever the stage
// behind it is willing to take its contents.
module int_to_fp_pipe #(
    parameter int INT_W = 32,
    parameter int EXP_W = 8,
    parameter int SIG_W = 24,
    parameter int TAG_W = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [INT_W-1:0]       in_data,
    input  logic [2:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W-1:0] out_data,
    output logic [4:0]             out_flags,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int LZ_W  = 7;
    localparam int EXT_W = INT_W + SIG_W + 2;
    localparam int E_W   = 12;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    logic               s1Valid, s1Sign;
    logic [INT_W-1:0]   s1Abs;
    logic [2:0]         s1Rm;
    logic [TAG_W-1:0]   s1Tag;

    logic               s2Valid, s2Sign, s2Zero;
    logic [INT_W-1:0]   s2Norm;
    logic [LZ_W-1:0]    s2Exp;
    logic [2:0]         s2Rm;
    logic [TAG_W-1:0]   s2Tag;

    logic               s3Valid;
    logic               adv1, adv2, adv3;

    logic               inNeg;
    logic [INT_W-1:0]   inAbs;
    logic [LZ_W-1:0]    lzCount;
    logic [INT_W-1:0]   normVal;
    logic [LZ_W-1:0]    expVal;
    logic               isZero;

    logic [EXT_W-1:0]   extVal;
    logic [SIG_W-1:0]   mant;
    logic               guardBit, stickyBit, incr, toInf, overflow, inexact;
    logic [SIG_W:0]     mantSum;
    logic [SIG_W-2:0]   fracRes;
    logic [E_W-1:0]     expFinal;
    logic [EXP_W-1:0]   expField;
    logic [EXP_W+SIG_W-1:0] packedRes;
    logic [4:0]         flagsRes;

    // A stage moves forward when it is empty or the next stage is moving.
    assign adv3      = ~s3Valid | out_ready;
    assign adv2      = ~s2Valid | adv3;
    assign adv1      = ~s1Valid | adv2;
    assign in_ready  = adv1 & ~flush;
    assign out_valid = s3Valid;
    assign busy      = s1Valid | s2Valid | s3Valid;

    // Sign extraction and magnitude; the magnitude of the most negative value fits as unsigned.
    always_comb begin
        inNeg = in_signed & in_data[INT_W-1];
        inAbs = inNeg ? (~in_data + INT_W'(1)) : in_data;
    end

    // Stage 1 register bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Abs   <= '0;
            s1Rm    <= '0;
            s1Tag   <= '0;
        end else if (flush) begin
            s1Valid <= 1'b0;
        end else if (adv1) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Sign <= inNeg;
                s1Abs  <= inAbs;
                s1Rm   <= in_rm;
                s1Tag  <= in_tag;
            end
        end
    end

    // Leading-zero count by scanning upward so the highest set bit wins.
    always_comb begin
        lzCount = LZ_W'(INT_W);
        for (int i = 0; i < INT_W; i++) begin
            if (s1Abs[i]) lzCount = LZ_W'(INT_W - 1 - i);
        end
        normVal = s1Abs << lzCount;
        expVal  = LZ_W'(INT_W - 1) - lzCount;
        isZero  = ~|s1Abs;
    end

    // Stage 2 register bank.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2Valid <= 1'b0;
            s2Sign  <= 1'b0;
            s2Zero  <= 1'b0;
            s2Norm  <= '0;
            s2Exp   <= '0;
            s2Rm    <= '0;
            s2Tag   <= '0;
        end else if (flush) begin
            s2Valid <= 1'b0;
        end else if (adv2) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Sign <= s1Sign;
                s2Zero <= isZero;
                s2Norm <= normVal;
                s2Exp  <= expVal;
                s2Rm   <= s1Rm;
                s2Tag  <= s1Tag;
            end
        end
    end

    // Rounding, carry-out renormalisation, overflow saturation and packing.
    always_comb begin
        extVal    = {s2Norm, {(SIG_W + 2){1'b0}}};
        mant      = extVal[EXT_W-1 -: SIG_W];
        guardBit  = extVal[EXT_W-1-SIG_W];
        stickyBit = |extVal[EXT_W-2-SIG_W:0];
        inexact   = guardBit | stickyBit;
        case (s2Rm)
            RM_RTZ: begin incr = 1'b0;               toInf = 1'b0;    end
            RM_RDN: begin incr = inexact & s2Sign;   toInf = s2Sign;  end
            RM_RUP: begin incr = inexact & ~s2Sign;  toInf = ~s2Sign; end
            RM_RMM: begin incr = guardBit;           toInf = 1'b1;    end
            default: begin incr = guardBit & (stickyBit | mant[0]); toInf = 1'b1; end
        endcase
        mantSum  = {1'b0, mant} + {{SIG_W{1'b0}}, incr};
        fracRes  = mantSum[SIG_W-1] ? mantSum[SIG_W-2:0] : '0;
        expFinal = E_W'(s2Exp) + E_W'(mantSum[SIG_W]);
        overflow = expFinal > E_W'(BIAS);
        expField = EXP_W'(expFinal + E_W'(BIAS));
        if (s2Zero) begin
            packedRes = '0;
            flagsRes  = '0;
        end else if (overflow) begin
            packedRes = toInf ? {s2Sign, {EXP_W{1'b1}}, {(SIG_W-1){1'b0}}}
                              : {s2Sign, {{(EXP_W-1){1'b1}}, 1'b0}, {(SIG_W-1){1'b1}}};
            flagsRes  = 5'b00101;
        end else begin
            packedRes = {s2Sign, expField, fracRes};
            flagsRes  = {4'b0000, inexact};
        end
    end

    // Stage 3 register bank drives the outputs directly and holds them while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s3Valid   <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            s3Valid <= 1'b0;
        end else if (adv3) begin
            s3Valid <= s2Valid;
            if (s2Valid) begin
                out_data  <= packedRes;
                out_flags <= flagsRes;
                out_tag   <= s2Tag;
            end
        end
    end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Bench for int_to_fp_pipe: a binary32 instance and a 16-bit-format instance,
// each scoreboarded against an arithmetic model of int-to-float rounding.
module tb_int_to_fp_pipe;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        aFlush, aValid, aInReady, aSigned, aOutValid, aOutReady, aBusy;
    logic [31:0] aData, aOutData;
    logic [2:0]  aRm;
    logic [4:0]  aTag, aOutTag, aFlags;

    logic        bFlush, bValid, bInReady, bSigned, bOutValid, bOutReady, bBusy;
    logic [31:0] bData;
    logic [15:0] bOutData;
    logic [2:0]  bRm;
    logic [4:0]  bTag, bOutTag, bFlags;

    int_to_fp_pipe #(.INT_W(32), .EXP_W(8), .SIG_W(24), .TAG_W(5)) dutA (
        .clock(clock), .reset(reset), .flush(aFlush),
        .in_valid(aValid), .in_ready(aInReady), .in_signed(aSigned),
        .in_data(aData), .in_rm(aRm), .in_tag(aTag),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .out_flags(aFlags), .out_tag(aOutTag), .busy(aBusy)
    );

    int_to_fp_pipe #(.INT_W(32), .EXP_W(5), .SIG_W(11), .TAG_W(5)) dutB (
        .clock(clock), .reset(reset), .flush(bFlush),
        .in_valid(bValid), .in_ready(bInReady), .in_signed(bSigned),
        .in_data(bData), .in_rm(bRm), .in_tag(bTag),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .out_flags(bFlags), .out_tag(bOutTag), .busy(bBusy)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [4:0]  tag;
        int          cyc;
    } expect_t;

    expect_t qA[$];
    expect_t qB[$];
    int nChecks = 0;
    int nFail = 0;
    int cyc = 0;
    bit strictLat = 1'b0;

    // Mathematical reference: exact magnitude, quotient/remainder rounding, saturation.
    function automatic logic [31:0] refConv(input int expW, input int sigW, input logic [31:0] val,
                                            input logic sgn, input logic [2:0] rm, output logic [4:0] flags);
        longint unsigned mag, q, rem, half, infBits, maxBits, signBit;
        int e, sh, bias;
        bit s, inc, toInf;
        logic [2:0] m;
        flags = 5'd0;
        s = sgn & val[31];
        mag = s ? (64'h1_0000_0000 - {32'h0, val}) : {32'h0, val};
        if (mag == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) e = i;
        m = (rm > 3'd4) ? 3'd0 : rm;
        bias = (1 << (expW - 1)) - 1;
        rem = 0;
        inc = 1'b0;
        if (e + 1 <= sigW) begin
            q = mag << (sigW - 1 - e);
        end else begin
            sh = e + 1 - sigW;
            q = mag >> sh;
            rem = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            case (m)
                3'd0: inc = (rem > half) || (rem == half && q[0]);
                3'd1: inc = 1'b0;
                3'd2: inc = (rem != 0) && s;
                3'd3: inc = (rem != 0) && !s;
                default: inc = (rem >= half);
            endcase
        end
        q = q + 64'(inc);
        if (q == (64'd1 << sigW)) begin
            q = q >> 1;
            e++;
        end
        signBit = s ? (64'd1 << (expW + sigW - 1)) : 64'd0;
        if (e > bias) begin
            case (m)
                3'd1: toInf = 1'b0;
                3'd2: toInf = s;
                3'd3: toInf = !s;
                default: toInf = 1'b1;
            endcase
            infBits = ((64'd1 << expW) - 1) << (sigW - 1);
            maxBits = infBits - 1;
            flags = 5'b00101;
            return 32'(signBit | (toInf ? infBits : maxBits));
        end
        flags = {4'b0000, rem != 0};
        return 32'(signBit | (64'(e + bias) << (sigW - 1)) | (q & ((64'd1 << (sigW - 1)) - 1)));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pinModel(input string name, input int expW, input int sigW, input logic [31:0] val,
                            input logic sgn, input logic [2:0] rm, input logic [31:0] res, input logic [4:0] fl);
        logic [4:0] f;
        logic [31:0] r;
        r = refConv(expW, sigW, val, sgn, rm, f);
        checkOutput(name, r, res);
        checkOutput({name, "Flags"}, {27'd0, f}, {27'd0, fl});
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard for the binary32 instance, including hold-while-stalled and busy tracking.
    logic        prevStall = 1'b0;
    logic [31:0] heldData;
    logic [4:0]  heldFlags, heldTag;
    always @(negedge clock) begin
        expect_t ent;
        logic [4:0] f;
        if (reset) begin
            qA.delete();
            prevStall = 1'b0;
        end else begin
            checkOutput("busyA", {31'd0, aBusy}, {31'd0, qA.size() != 0});
            if (prevStall) begin
                checkOutput("stallValid", {31'd0, aOutValid}, 32'd1);
                checkOutput("stallData", aOutData, heldData);
                checkOutput("stallFlags", {27'd0, aFlags}, {27'd0, heldFlags});
                checkOutput("stallTag", {27'd0, aOutTag}, {27'd0, heldTag});
            end
            if (aFlush) begin
                qA.delete();
            end else begin
                if (aOutValid && aOutReady) begin
                    if (qA.size() == 0) begin
                        checkOutput("spuriousA", {31'd0, aOutValid}, 32'd0);
                    end else begin
                        ent = qA.pop_front();
                        checkOutput("dataA", aOutData, ent.res);
                        checkOutput("flagsA", {27'd0, aFlags}, {27'd0, ent.flags});
                        checkOutput("tagA", {27'd0, aOutTag}, {27'd0, ent.tag});
                        if (strictLat) checkOutput("latencyA", cyc - ent.cyc, 32'd3);
                    end
                end
                if (aValid && aInReady) begin
                    ent.res = refConv(8, 24, aData, aSigned, aRm, f);
                    ent.flags = f;
                    ent.tag = aTag;
                    ent.cyc = cyc;
                    qA.push_back(ent);
                end
            end
            prevStall = aOutValid && !aOutReady && !aFlush;
            heldData = aOutData;
            heldFlags = aFlags;
            heldTag = aOutTag;
        end
    end

    // Scoreboard for the narrow-format instance.
    always @(negedge clock) begin
        expect_t ent;
        logic [4:0] f;
        if (reset) begin
            qB.delete();
        end else begin
            checkOutput("busyB", {31'd0, bBusy}, {31'd0, qB.size() != 0});
            if (bOutValid && bOutReady) begin
                if (qB.size() == 0) begin
                    checkOutput("spuriousB", {31'd0, bOutValid}, 32'd0);
                end else begin
                    ent = qB.pop_front();
                    checkOutput("dataB", {16'd0, bOutData}, ent.res);
                    checkOutput("flagsB", {27'd0, bFlags}, {27'd0, ent.flags});
                    checkOutput("tagB", {27'd0, bOutTag}, {27'd0, ent.tag});
                    if (strictLat) checkOutput("latencyB", cyc - ent.cyc, 32'd3);
                end
            end
            if (bValid && bInReady) begin
                ent.res = refConv(5, 11, bData, bSigned, bRm, f);
                ent.flags = f;
                ent.tag = bTag;
                ent.cyc = cyc;
                qB.push_back(ent);
            end
        end
    end

    task automatic applyStimulus(input logic sgn, input logic [31:0] data, input logic [2:0] rm, input logic [4:0] tag);
        @(posedge clock);
        #1;
        aValid = 1'b1; aSigned = sgn; aData = data; aRm = rm; aTag = tag;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (aInReady) return;
        end
        checkOutput("acceptTimeoutA", {31'd0, aInReady}, 32'd1);
    endtask

    task automatic applyStimulusB(input logic sgn, input logic [31:0] data, input logic [2:0] rm, input logic [4:0] tag);
        @(posedge clock);
        #1;
        bValid = 1'b1; bSigned = sgn; bData = data; bRm = rm; bTag = tag;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bInReady) return;
        end
        checkOutput("acceptTimeoutB", {31'd0, bInReady}, 32'd1);
    endtask

    task automatic idleInputs();
        @(posedge clock);
        #1;
        aValid = 1'b0;
        bValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (qA.size() == 0 && qB.size() == 0 && !aBusy && !bBusy) return;
        end
        checkOutput("drainTimeout", qA.size() + qB.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        aFlush = 0; aValid = 0; aSigned = 0; aData = 0; aRm = 0; aTag = 0; aOutReady = 1;
        bFlush = 0; bValid = 0; bSigned = 0; bData = 0; bRm = 0; bTag = 0; bOutReady = 1;

        pinModel("pinNeg1",    8, 24, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 5'h00);
        pinModel("pinMinInt",  8, 24, 32'h8000_0000, 1'b1, 3'd0, 32'hCF00_0000, 5'h00);
        pinModel("pinZero",    8, 24, 32'h0000_0000, 1'b1, 3'd3, 32'h0000_0000, 5'h00);
        pinModel("pinMaxRne",  8, 24, 32'h7FFF_FFFF, 1'b1, 3'd0, 32'h4F00_0000, 5'h01);
        pinModel("pinMaxRtz",  8, 24, 32'h7FFF_FFFF, 1'b1, 3'd1, 32'h4EFF_FFFF, 5'h01);
        pinModel("pinUnsAll",  8, 24, 32'hFFFF_FFFF, 1'b0, 3'd0, 32'h4F80_0000, 5'h01);
        pinModel("pinTieRne",  8, 24, 32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 5'h01);
        pinModel("pinTieRup",  8, 24, 32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 5'h01);
        pinModel("pinOne",     8, 24, 32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 5'h00);
        pinModel("pinHMax",    5, 11, 32'd65504,     1'b0, 3'd0, 32'h7BFF,      5'h00);
        pinModel("pinHOvRne",  5, 11, 32'd65520,     1'b0, 3'd0, 32'h7C00,      5'h05);
        pinModel("pinHRtz",    5, 11, 32'd65520,     1'b0, 3'd1, 32'h7BFF,      5'h01);
        pinModel("pinHNegRdn", 5, 11, 32'hFFFF_0010, 1'b1, 3'd2, 32'hFC00,      5'h05);
        pinModel("pinHNegRup", 5, 11, 32'hFFFF_0010, 1'b1, 3'd3, 32'hFBFF,      5'h01);
        pinModel("pinHOvRtz",  5, 11, 32'd65536,     1'b0, 3'd1, 32'h7BFF,      5'h05);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstValid", {31'd0, aOutValid}, 32'd0);
        checkOutput("rstBusy", {31'd0, aBusy}, 32'd0);
        checkOutput("rstData", aOutData, 32'd0);
        checkOutput("rstFlags", {27'd0, aFlags}, 32'd0);
        checkOutput("rstTag", {27'd0, aOutTag}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rstReady", {31'd0, aInReady}, 32'd1);

        // Directed conversions, back to back, with latency pinned at three cycles.
        strictLat = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 3'd0, 5'd1);
        applyStimulus(1'b1, 32'h8000_0000, 3'd0, 5'd2);
        applyStimulus(1'b1, 32'h0000_0000, 3'd0, 5'd3);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 3'd0, 5'd4);
        applyStimulus(1'b1, 32'h7FFF_FFFF, 3'd1, 5'd5);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 3'd0, 5'd6);
        applyStimulus(1'b0, 32'h0100_0001, 3'd0, 5'd7);
        applyStimulus(1'b0, 32'h0100_0001, 3'd3, 5'd8);
        applyStimulus(1'b1, 32'h0000_0000, 3'd2, 5'd9);
        idleInputs();
        applyStimulusB(1'b0, 32'd65504,     3'd0, 5'd1);
        applyStimulusB(1'b0, 32'd65520,     3'd0, 5'd2);
        applyStimulusB(1'b0, 32'd65520,     3'd1, 5'd3);
        applyStimulusB(1'b1, 32'hFFFF_0010, 3'd2, 5'd4);
        applyStimulusB(1'b1, 32'hFFFF_0010, 3'd3, 5'd5);
        applyStimulusB(1'b0, 32'd65536,     3'd1, 5'd6);
        applyStimulusB(1'b1, 32'hFFFF_0010, 3'd4, 5'd7);
        idleInputs();
        drain();
        strictLat = 1'b0;

        // Backpressure: three fit, the fourth waits.
        @(posedge clock);
        #1;
        aOutReady = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clock);
            #1;
            aValid = 1'b1; aSigned = 1'b1; aData = 32'h0000_1000 * t + 32'd3; aRm = 3'd0; aTag = 5'(t);
            @(negedge clock);
            checkOutput("bpReady", {31'd0, aInReady}, {31'd0, t <= 3});
        end
        repeat (4) begin
            @(negedge clock);
            checkOutput("bpHeld", {31'd0, aInReady}, 32'd0);
        end
        @(posedge clock);
        #1;
        aOutReady = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (aInReady) break;
        end
        idleInputs();
        drain();

        // Flush with a full pipe and a simultaneous offer.
        @(posedge clock);
        #1;
        aOutReady = 1'b0;
        applyStimulus(1'b0, 32'd100, 3'd0, 5'd11);
        applyStimulus(1'b0, 32'd200, 3'd0, 5'd12);
        applyStimulus(1'b0, 32'd300, 3'd0, 5'd13);
        @(posedge clock);
        #1;
        aFlush = 1'b1; aData = 32'd400; aTag = 5'd14;
        @(negedge clock);
        checkOutput("flushReady", {31'd0, aInReady}, 32'd0);
        @(posedge clock);
        #1;
        aFlush = 1'b0; aValid = 1'b0; aOutReady = 1'b1;
        @(negedge clock);
        checkOutput("flushBusy", {31'd0, aBusy}, 32'd0);
        checkOutput("flushValid", {31'd0, aOutValid}, 32'd0);
        strictLat = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_CFC7, 3'd0, 5'd15);
        idleInputs();
        drain();
        strictLat = 1'b0;

        // Randomised traffic with random backpressure and occasional flushes.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] x;
            @(posedge clock);
            #1;
            aValid = ($urandom_range(0, 3) != 0);
            aSigned = 1'($urandom_range(0, 1));
            aRm = 3'($urandom_range(0, 7));
            aTag = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: aData = $urandom();
                1: aData = 32'($urandom_range(0, 255));
                2: aData = 32'h8000_0000 >> $urandom_range(0, 31);
                3: aData = $urandom() & 32'hFFFF_FF80;
                default: aData = 32'hFFFF_FFFF - 32'($urandom_range(0, 300));
            endcase
            aOutReady = ($urandom_range(0, 3) != 0);
            aFlush = ($urandom_range(0, 49) == 0);
            x = 32'($urandom_range(0, 131071));
            bValid = ($urandom_range(0, 1) != 0);
            bRm = 3'($urandom_range(0, 7));
            bTag = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) != 0) begin
                bSigned = 1'b1;
                bData = 32'd0 - x;
            end else begin
                bSigned = 1'($urandom_range(0, 1));
                bData = ($urandom_range(0, 7) == 0) ? $urandom() : x;
            end
            bOutReady = ($urandom_range(0, 3) != 0);
        end
        @(posedge clock);
        #1;
        aValid = 0; bValid = 0; aFlush = 0; aOutReady = 1; bOutReady = 1;
        drain();

        // Asynchronous reset with a full pipe, then a fresh conversion.
        @(posedge clock);
        #1;
        aOutReady = 1'b0;
        applyStimulus(1'b0, 32'd5, 3'd0, 5'd21);
        applyStimulus(1'b0, 32'd6, 3'd0, 5'd22);
        applyStimulus(1'b0, 32'd7, 3'd0, 5'd23);
        @(posedge clock);
        #1;
        aValid = 1'b0;
        #1;
        checkOutput("preResetValid", {31'd0, aOutValid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("asyncValid", {31'd0, aOutValid}, 32'd0);
        checkOutput("asyncBusy", {31'd0, aBusy}, 32'd0);
        checkOutput("asyncData", aOutData, 32'd0);
        @(negedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        aOutReady = 1'b1;
        @(negedge clock);
        checkOutput("postResetReady", {31'd0, aInReady}, 32'd1);
        strictLat = 1'b1;
        applyStimulus(1'b0, 32'd1, 3'd0, 5'd24);
        idleInputs();
        drain();
        strictLat = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
